// File: rtl/sieve_pkg.sv
// Shared types and constants for the sieve controller.
// Contents: sequencer state enum, bitmap bus widths, sieve limit, and a
// saturating 6-bit increment used for the prime counter.
package sieve_pkg;

    localparam int SIEVE_AW = 8;
    localparam int SIEVE_DW = 8;
    localparam logic [SIEVE_DW-1:0] SIEVE_MAX = 8'd100;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        DONE
    } state_t;

    function automatic logic [5:0] sat_inc6(input logic [5:0] v);
        return (v == 6'd63) ? v : v + 6'd1;
    endfunction

endpackage

// File: rtl/sieve_prime_fifo.sv
// First-word fall-through FIFO holding the primes reported by the engine.
// Ports:
//   clk, rst      clock, asynchronous active-low reset (empties the FIFO)
//   flush         synchronous empty, wins over push/pop
//   push, din     write; the caller only pushes when not full, or when a pop
//                 happens in the same cycle (the pop frees the slot first)
//   pop           advance head; ignored when empty
//   dout          head entry, valid while !empty
//   full, empty   status
module sieve_prime_fifo #(
    parameter int DEPTH = 32,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    // One extra pointer bit separates full from empty.
    logic [AW:0]   wp, rp;
    logic [AW:0]   ptr_one;

    assign ptr_one = {{AW{1'b0}}, 1'b1};
    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout    = mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push)
                wp <= wp + ptr_one;
            if (pop && !empty)
                rp <= rp + ptr_one;
        end
    end

    // At full with a simultaneous pop, wp indexes the slot being popped this
    // cycle, so overwriting it on the same edge is safe.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sieve_ctrl.sv
// Sequencer and bitmap-RAM owner for the prime sieve engine.
// Holds the engine in reset until start, gives it the RAM for the whole run,
// captures reported primes into a FIFO drained by the host (valid/ready),
// and flags completion.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   start                         begin a run (honoured in IDLE/DONE only)
//   busy, done                    CLEAR/RUN, DONE status
//   overflow                      sticky prime-dropped flag, cleared by start
//   prm_count                     primes accepted this run, saturating
//   prm_valid/prm_ready/prm_data  prime FIFO head handshake
//   eng_rst                       synchronous reset to engine, low only in RUN
//   eng_wr/eng_addr/eng_dout      engine RAM request / reported prime
//   eng_rdy, eng_done             engine result-valid level, completion
//   eng_din                       RAM read data back to engine
//   mem_we/mem_addr/mem_wdata     RAM request
//   mem_rdata                     RAM read data, 1-cycle latency
// Optional feature, macro SIEVE_BITMAP_RD_EN: host bitmap readback ports
//   bm_req/bm_addr (in), bm_ack/bm_data (out), served in IDLE/DONE only.
module sieve_ctrl
    import sieve_pkg::*;
#(
    parameter int FIFO_DEPTH = 32,
    parameter int CLR_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [5:0]          prm_count,
    output logic                prm_valid,
    input  logic                prm_ready,
    output logic [SIEVE_DW-1:0] prm_data,
    output logic                eng_rst,
    input  logic                eng_wr,
    input  logic [SIEVE_AW-1:0] eng_addr,
    input  logic [SIEVE_DW-1:0] eng_dout,
    input  logic                eng_rdy,
    input  logic                eng_done,
    output logic [SIEVE_DW-1:0] eng_din,
    output logic                mem_we,
    output logic [SIEVE_AW-1:0] mem_addr,
    output logic [SIEVE_DW-1:0] mem_wdata,
    input  logic [SIEVE_DW-1:0] mem_rdata
`ifdef SIEVE_BITMAP_RD_EN
   ,input  logic                bm_req,
    input  logic [SIEVE_AW-1:0] bm_addr,
    output logic                bm_ack,
    output logic [SIEVE_DW-1:0] bm_data
`endif
);
    state_t              state;
    logic [3:0]          clr_cnt;
    logic [SIEVE_DW-1:0] last;
    logic                run, idle, flush, pop_fire, new_prime, accept;
    logic                full, empty;

    assign run       = (state == RUN);
    assign idle      = (state == IDLE) || (state == DONE);
    assign flush     = start & idle;
    assign prm_valid = ~empty;
    assign pop_fire  = prm_valid & prm_ready;
    // The engine holds eng_rdy as a level; only a changed value is a new prime.
    assign new_prime = run & eng_rdy & (eng_dout != last);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign accept    = new_prime & (~full | pop_fire);
    assign eng_din   = mem_rdata;

    sieve_prime_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (SIEVE_DW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (accept),
        .pop   (pop_fire),
        .din   (eng_dout),
        .dout  (prm_data),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            clr_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            prm_count <= '0;
            eng_rst   <= 1'b1;
            last      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= CLEAR;
                        clr_cnt   <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        overflow  <= 1'b0;
                        prm_count <= '0;
                        last      <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == 4'(CLR_CYCLES - 1)) begin
                        state   <= RUN;
                        eng_rst <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 4'd1;
                    end
                end
                RUN: begin
                    if (new_prime) begin
                        last <= eng_dout;
                        if (accept)
                            prm_count <= sat_inc6(prm_count);
                        else
                            overflow <= 1'b1;
                    end
                    if (eng_done) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        eng_rst <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Engine outputs are meaningless outside RUN (its reset drives wr=1),
    // so they never reach the RAM there.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (run) begin
            mem_we    = eng_wr;
            mem_addr  = eng_addr;
            mem_wdata = eng_dout;
        end
`ifdef SIEVE_BITMAP_RD_EN
        else if (idle && bm_req) begin
            mem_addr = bm_addr;
        end
`endif
    end

`ifdef SIEVE_BITMAP_RD_EN
    // vld_pipe[1]: RAM read issued last cycle; vld_pipe[2]: ack cycle.
    // A request held across CLEAR/RUN issues on the first DONE cycle.
    logic [2:1] vld_pipe;
    logic       bm_issue;

    assign bm_issue = bm_req & idle & ~(|vld_pipe);
    assign bm_ack   = vld_pipe[2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            bm_data  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], bm_issue};
            if (vld_pipe[1])
                bm_data <= mem_rdata;
        end
    end
`endif

endmodule
